// File: rtl/sap_sequencer_if.sv
// Control bundle between the SAP microcode sequencer and the CPU datapath / IR.
// The master modport is the sequencer, which drives the control word and status.
// The slave modport is the datapath side, which drives run, opcode and the ALU flags.
interface sap_sequencer_if #(
  parameter int OPW   = 4,
  parameter int STEPS = 8,
  parameter int CW    = 16
);
  localparam int SW = $clog2(STEPS);

  logic           run;
  logic [OPW-1:0] opcode;
  logic           carry_in;
  logic           zero_in;
  logic [CW-1:0]  ctrl;
  logic [SW-1:0]  step;
  logic           last;
  logic [1:0]     flags;
  logic           halted;

  modport master (
    input  run, opcode, carry_in, zero_in,
    output ctrl, step, last, flags, halted
  );

  modport slave (
    output run, opcode, carry_in, zero_in,
    input  ctrl, step, last, flags, halted
  );
endinterface

// File: rtl/sap_sequencer.sv
// Microcode sequencer for the 8-bit SAP CPU: control word from opcode, microstep and flags.
// Latency: ctrl/last are combinational from current state; step/flags/halt update each posedge.
// Backpressure: run=0 stalls (ctrl=0, state held); a halted sequencer ignores run until rst.
module sap_sequencer #(
  parameter int OPW   = 4,
  parameter int STEPS = 8,
  parameter int CW    = 16
) (
  input logic             CLK,
  input logic             rst,
  sap_sequencer_if.master bus
);
  localparam int SW = $clog2(STEPS);

  // Control word bit masks (datapath wiring order).
  localparam logic [15:0] M_J   = 16'h0001;
  localparam logic [15:0] M_CO  = 16'h0002;
  localparam logic [15:0] M_CE  = 16'h0004;
  localparam logic [15:0] M_OI  = 16'h0008;
  localparam logic [15:0] M_BI  = 16'h0010;
  localparam logic [15:0] M_SU  = 16'h0020;
  localparam logic [15:0] M_SO  = 16'h0040;
  localparam logic [15:0] M_AO  = 16'h0080;
  localparam logic [15:0] M_AI  = 16'h0100;
  localparam logic [15:0] M_II  = 16'h0200;
  localparam logic [15:0] M_IO  = 16'h0400;
  localparam logic [15:0] M_RO  = 16'h0800;
  localparam logic [15:0] M_RI  = 16'h1000;
  localparam logic [15:0] M_MI  = 16'h2000;
  localparam logic [15:0] M_HLT = 16'h4000;
  localparam int          B_FI  = 15;

  // Opcodes, zero-extended to the IR opcode width.
  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4);
  localparam logic [OPW-1:0] OP_LDI = OPW'(5);
  localparam logic [OPW-1:0] OP_JMP = OPW'(6);
  localparam logic [OPW-1:0] OP_JC  = OPW'(7);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
  localparam logic [OPW-1:0] OP_OUT = OPW'(14);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [1:0]    flags_q, flags_d;

  logic [15:0]   cw;          // decoded microinstruction before run/halt/reset gating
  logic          last_w;      // decoded end-of-instruction marker
  logic          halt_entry;  // HLT executing at T2
  logic [CW-1:0] ctrl_w;
  logic          last_o;

  // Microcode ROM: decode (step, opcode, flags) into a raw control word.
  always_comb begin
    cw         = 16'h0000;
    last_w     = 1'b0;
    halt_entry = 1'b0;
    if (step_q == SW'(0)) begin
      cw = M_MI | M_CO;
    end else if (step_q == SW'(1)) begin
      cw = M_RO | M_II | M_CE;
    end else if (step_q == SW'(2)) begin
      last_w = 1'b1;
      case (bus.opcode)
        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
          cw     = M_MI | M_IO;
          last_w = 1'b0;
        end
        OP_LDI:  cw = M_IO | M_AI;
        OP_JMP:  cw = M_IO | M_J;
        OP_JC:   cw = flags_q[1] ? (M_IO | M_J) : 16'h0000;
        OP_JZ:   cw = flags_q[0] ? (M_IO | M_J) : 16'h0000;
        OP_OUT:  cw = M_AO | M_OI;
        OP_HLT: begin
          cw         = M_HLT;
          last_w     = 1'b0;
          halt_entry = 1'b1;
        end
        default: cw = 16'h0000;
      endcase
    end else if (step_q == SW'(3)) begin
      case (bus.opcode)
        OP_LDA: begin
          cw     = M_RO | M_AI;
          last_w = 1'b1;
        end
        OP_ADD, OP_SUB: cw = M_RO | M_BI;
        OP_STA: begin
          cw     = M_AO | M_RI;
          last_w = 1'b1;
        end
        default: cw = 16'h0000;
      endcase
    end else if (step_q == SW'(4)) begin
      case (bus.opcode)
        OP_ADD: begin
          cw     = M_SO | M_AI | (16'h1 << B_FI);
          last_w = 1'b1;
        end
        OP_SUB: begin
          cw     = M_SO | M_SU | M_AI | (16'h1 << B_FI);
          last_w = 1'b1;
        end
        default: cw = 16'h0000;
      endcase
    end
  end

  // Output gating: reset blanks everything, halt forces HLT only, stall blanks ctrl/last.
  always_comb begin
    ctrl_w = '0;
    last_o = 1'b0;
    if (rst) begin
      ctrl_w = '0;
    end else if (state_q == ST_HALT) begin
      ctrl_w[15:0] = M_HLT;
    end else if (bus.run) begin
      ctrl_w[15:0] = cw;
      last_o       = last_w;
    end
  end

  // Next state: advance/wrap the microstep, latch flags on FI, enter halt at HLT T2.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    flags_d = flags_q;
    if (state_q == ST_RUN && bus.run) begin
      if (halt_entry) begin
        state_d = ST_HALT;
      end else if (last_w || step_q == SW'(STEPS - 1)) begin
        step_d = '0;
      end else begin
        step_d = step_q + 1'b1;
      end
      if (cw[B_FI]) begin
        flags_d = {bus.carry_in, bus.zero_in};
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= ST_RUN;
      step_q  <= '0;
      flags_q <= 2'b00;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      flags_q <= flags_d;
    end
  end

  assign bus.ctrl   = ctrl_w;
  assign bus.last   = last_o;
  assign bus.step   = step_q;
  assign bus.flags  = flags_q;
  assign bus.halted = (state_q == ST_HALT);
endmodule

// File: tb/tb_sap_sequencer.sv
// Self-checking bench for sap_sequencer: per-scenario tasks drive one row per cycle,
// push the expected outputs to a scoreboard queue and pop/compare before the next edge.
module tb_sap_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sap_sequencer_if #(.OPW(4), .STEPS(8), .CW(16)) bus ();

  sap_sequencer #(.OPW(4), .STEPS(8), .CW(16)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        last;
    logic [1:0]  flags;
    logic        halted;
  } exp_t;

  typedef struct packed {
    logic       r;
    logic       run;
    logic [3:0] op;
    logic       c;
    logic       z;
    exp_t       e;
  } row_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic row_t R(input int r, input int run, input int op, input int c, input int z,
                             input int ctrl, input int st, input int l, input int f, input int h);
    row_t x;
    x.r        = 1'(r);
    x.run      = 1'(run);
    x.op       = 4'(op);
    x.c        = 1'(c);
    x.z        = 1'(z);
    x.e.ctrl   = 16'(ctrl);
    x.e.step   = 3'(st);
    x.e.last   = 1'(l);
    x.e.flags  = 2'(f);
    x.e.halted = 1'(h);
    return x;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.ctrl   = bus.ctrl;
    o.step   = bus.step;
    o.last   = bus.last;
    o.flags  = bus.flags;
    o.halted = bus.halted;
    return o;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("ctrl=%h step=%0d last=%b flags=%b halted=%b",
                     e.ctrl, e.step, e.last, e.flags, e.halted);
  endfunction

  // Drive one cycle of stimulus at the falling edge and record its expected outputs.
  task automatic apply(input row_t x);
    @(negedge clk);
    rst          = x.r;
    bus.run      = x.run;
    bus.opcode   = x.op;
    bus.carry_in = x.c;
    bus.zero_in  = x.z;
    sb.push_back(x.e);
    #1;
  endtask

  task automatic test_reset();
    row_t t[2];
    exp_t got, want;
    t = '{R(1,1,1,0,0, 'h0000,0,0,0,0), R(1,1,1,0,0, 'h0000,0,0,0,0)};
    foreach (t[i]) begin
      apply(t[i]);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_lda();
    row_t t[4];
    exp_t got, want;
    t = '{R(0,1,1,0,0, 'h2002,0,0,0,0), R(0,1,1,0,0, 'h0A04,1,0,0,0),
          R(0,1,1,0,0, 'h2400,2,0,0,0), R(0,1,1,0,0, 'h0900,3,1,0,0)};
    foreach (t[i]) begin
      apply(t[i]);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL lda[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_add();
    row_t t[5];
    exp_t got, want;
    t = '{R(0,1,2,1,0, 'h2002,0,0,0,0), R(0,1,2,1,0, 'h0A04,1,0,0,0),
          R(0,1,2,1,0, 'h2400,2,0,0,0), R(0,1,2,1,0, 'h0810,3,0,0,0),
          R(0,1,2,1,0, 'h8140,4,1,0,0)};
    foreach (t[i]) begin
      apply(t[i]);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL add[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // JC taken on carry, then an ADD leaving {carry,zero}=01: JC not taken, JZ taken.
  task automatic test_cond_jump();
    row_t t[14];
    exp_t got, want;
    t = '{R(0,1,7,0,0, 'h2002,0,0,2,0), R(0,1,7,0,0, 'h0A04,1,0,2,0),
          R(0,1,7,0,0, 'h0401,2,1,2,0),
          R(0,1,2,0,1, 'h2002,0,0,2,0), R(0,1,2,0,1, 'h0A04,1,0,2,0),
          R(0,1,2,0,1, 'h2400,2,0,2,0), R(0,1,2,0,1, 'h0810,3,0,2,0),
          R(0,1,2,0,1, 'h8140,4,1,2,0),
          R(0,1,7,1,0, 'h2002,0,0,1,0), R(0,1,7,1,0, 'h0A04,1,0,1,0),
          R(0,1,7,1,0, 'h0000,2,1,1,0),
          R(0,1,8,0,0, 'h2002,0,0,1,0), R(0,1,8,0,0, 'h0A04,1,0,1,0),
          R(0,1,8,0,0, 'h0401,2,1,1,0)};
    foreach (t[i]) begin
      apply(t[i]);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL cond_jump[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_stall();
    row_t t[9];
    exp_t got, want;
    t = '{R(0,1,3,1,1, 'h2002,0,0,1,0), R(0,1,3,1,1, 'h0A04,1,0,1,0),
          R(0,1,3,1,1, 'h2400,2,0,1,0),
          R(0,0,3,1,1, 'h0000,3,0,1,0), R(0,0,3,0,0, 'h0000,3,0,1,0),
          R(0,0,3,1,0, 'h0000,3,0,1,0), R(0,0,3,1,1, 'h0000,3,0,1,0),
          R(0,1,3,1,1, 'h0810,3,0,1,0), R(0,1,3,1,1, 'h8160,4,1,1,0)};
    foreach (t[i]) begin
      apply(t[i]);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL stall[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Reset at T3 of ADD with flags=11, then an undefined opcode runs T0..T2 only.
  task automatic test_rst_mid();
    row_t t[8];
    exp_t got, want;
    t = '{R(0,1,2,0,0, 'h2002,0,0,3,0), R(0,1,2,0,0, 'h0A04,1,0,3,0),
          R(0,1,2,0,0, 'h2400,2,0,3,0), R(1,1,2,0,0, 'h0000,3,0,3,0),
          R(0,1,10,0,0, 'h2002,0,0,0,0), R(0,1,10,0,0, 'h0A04,1,0,0,0),
          R(0,1,10,0,0, 'h0000,2,1,0,0), R(0,1,10,0,0, 'h2002,0,0,0,0)};
    foreach (t[i]) begin
      apply(t[i]);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rst_mid[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // LDI, STA, OUT, JMP, NOP back to back (enters at T1 from the previous task's T0).
  task automatic test_back_to_back();
    row_t t[15];
    exp_t got, want;
    t = '{R(0,1,5,0,0, 'h0A04,1,0,0,0), R(0,1,5,0,0, 'h0500,2,1,0,0),
          R(0,1,4,0,0, 'h2002,0,0,0,0), R(0,1,4,0,0, 'h0A04,1,0,0,0),
          R(0,1,4,0,0, 'h2400,2,0,0,0), R(0,1,4,0,0, 'h1080,3,1,0,0),
          R(0,1,14,0,0, 'h2002,0,0,0,0), R(0,1,14,0,0, 'h0A04,1,0,0,0),
          R(0,1,14,0,0, 'h0088,2,1,0,0),
          R(0,1,6,0,0, 'h2002,0,0,0,0), R(0,1,6,0,0, 'h0A04,1,0,0,0),
          R(0,1,6,0,0, 'h0401,2,1,0,0),
          R(0,1,0,0,0, 'h2002,0,0,0,0), R(0,1,0,0,0, 'h0A04,1,0,0,0),
          R(0,1,0,0,0, 'h0000,2,1,0,0)};
    foreach (t[i]) begin
      apply(t[i]);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // HLT: sticky for 10 cycles regardless of run and ALU inputs; only rst clears it.
  task automatic test_halt();
    row_t t[$];
    exp_t got, want;
    t.push_back(R(0,1,15,0,0, 'h2002,0,0,0,0));
    t.push_back(R(0,1,15,0,0, 'h0A04,1,0,0,0));
    t.push_back(R(0,1,15,0,0, 'h4000,2,0,0,0));
    for (int k = 0; k < 10; k++) t.push_back(R(0,k%2,15,1,1, 'h4000,2,0,0,1));
    t.push_back(R(1,1,15,0,0, 'h0000,2,0,0,1));
    t.push_back(R(0,1,15,0,0, 'h2002,0,0,0,0));
    t.push_back(R(0,1,15,0,0, 'h0A04,1,0,0,0));
    foreach (t[i]) begin
      apply(t[i]);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL halt[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.run      = 1'b1;
    bus.opcode   = 4'h1;
    bus.carry_in = 1'b0;
    bus.zero_in  = 1'b0;
    test_reset();
    test_lda();
    test_add();
    test_cond_jump();
    test_stall();
    test_rst_mid();
    test_back_to_back();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
